// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types, constants and helpers for pipe_stage_chain (build option: PIPE_FLUSH_ZERO_EN)
package pipe_pkg;

    // Each data bit a flushed stage loads when zero-on-flush is built in.
    // Reset always loads zeros as well.
    localparam logic FLUSH_DATA_BIT = 1'b0;

    // Widest chain that popcount can count.
    localparam int PIPE_MAX_DEPTH = 32;

    // Stage entry layout {valid, data}. The data field is sized to the widest supported payload.
    // Cells declare their own WIDTH-sized copy of this layout.
    localparam int PIPE_MAX_WIDTH = 64;
    typedef struct packed {
        logic                      valid;
        logic [PIPE_MAX_WIDTH-1:0] data;
    } pipe_entry_t;

    // Counts the set bits of a valid vector. The caller zero-extends the vector to PIPE_MAX_DEPTH bits.
    function automatic logic [31:0] popcount(input logic [PIPE_MAX_DEPTH-1:0] bits);
        logic [31:0] cnt;
        cnt = '0;
        for (int i = 0; i < PIPE_MAX_DEPTH; i++) begin
            cnt = cnt + {31'd0, bits[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/pipe_stage_cell.sv
// rtl/pipe_stage_cell.sv - one {valid,data} pipeline register with hold, kill and sync active-low reset (build option: PIPE_FLUSH_ZERO_EN)
module pipe_stage_cell
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             kill_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             v_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             nxt_valid_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // Next state: shift in or hold, then apply the kill to whichever entry lands here.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (en_i) begin
            data_d  = d_i;
            valid_d = v_i;
        end
        if (kill_i) begin
            valid_d = 1'b0;
`ifdef PIPE_FLUSH_ZERO_EN
            data_d  = {WIDTH{FLUSH_DATA_BIT}};
`endif
        end
    end

    // Stage register. Reset wins over every other input.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign nxt_valid_o = valid_d;

endmodule

// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - DEPTH-stage payload/valid chain with stall, per-stage flush and occupancy (build option: PIPE_FLUSH_ZERO_EN)
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic [DEPTH-1:0] flush_mask,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic [DEPTH-1:0] stage_valid,
    output logic [CNT_W-1:0] occupancy
);

    logic [WIDTH-1:0]          stage_data [DEPTH];
    logic [DEPTH-1:0]          nxt_valid;
    logic [PIPE_MAX_DEPTH-1:0] pop_in;
    logic [CNT_W-1:0]          occupancy_q, occupancy_d;

    // Stage 0 takes the input port; every later stage takes its predecessor.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] src_data;
        logic             src_valid;
        if (i == 0) begin : g_head
            assign src_data  = in_data;
            assign src_valid = in_valid;
        end else begin : g_body
            assign src_data  = stage_data[i-1];
            assign src_valid = stage_valid[i-1];
        end

        pipe_stage_cell #(.WIDTH(WIDTH)) u_cell (
            .clk         (clk),
            .reset       (reset),
            .en_i        (en),
            .kill_i      (flush_mask[i]),
            .d_i         (src_data),
            .v_i         (src_valid),
            .data_o      (stage_data[i]),
            .valid_o     (stage_valid[i]),
            .nxt_valid_o (nxt_valid[i])
        );
    end

    // Occupancy is counted from next-state valids so it matches stage_valid on the same cycle.
    always_comb begin
        pop_in              = '0;
        pop_in[DEPTH-1:0]   = nxt_valid;
        occupancy_d         = CNT_W'(popcount(pop_in));
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            occupancy_q <= '0;
        end else begin
            occupancy_q <= occupancy_d;
        end
    end

    assign out_data  = stage_data[DEPTH-1];
    assign out_valid = stage_valid[DEPTH-1];
    assign occupancy = occupancy_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb/tb_pipe_stage_chain.sv - directed self-checking bench for pipe_stage_chain (WIDTH=32, DEPTH=3)
module tb_pipe_stage_chain;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [31:0] in_data;
    logic        in_valid;
    logic [2:0]  flush_mask;
    logic [31:0] out_data;
    logic        out_valid;
    logic [2:0]  stage_valid;
    logic [1:0]  occupancy;

    int errors = 0;
    int checks = 0;

    pipe_stage_chain #(.WIDTH(32), .DEPTH(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .flush_mask  (flush_mask),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .stage_valid (stage_valid),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        en = 1'b1; in_valid = 1'b1; in_data = d; flush_mask = 3'b000;
        step();
    endtask

    task automatic clear_chain();
        en = 1'b1; in_valid = 1'b0; flush_mask = 3'b111;
        step();
        flush_mask = 3'b000;
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF; flush_mask = 3'b000;
        step();
        step();
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data: got %h want %h", out_data, 32'h0); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (stage_valid !== 3'b000) begin errors++; $display("FAIL rst_stage_valid: got %b want 000", stage_valid); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rst_occupancy: got %0d want 0", occupancy); end
        reset = 1'b1;
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_latency_early: got %b want 0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rst_latency3: got %b/%h want 1/deadbeef", out_valid, out_data); end
        clear_chain();
    endtask

    task automatic test_streaming();
        push(32'd1);
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL stream_occ1: got %0d want 1", occupancy); end
        push(32'd2);
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL stream_occ2: got %0d want 2", occupancy); end
        push(32'd3);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'd1) begin errors++; $display("FAIL stream_out1: got %b/%h want 1/1", out_valid, out_data); end
        checks++; if (occupancy !== 2'd3) begin errors++; $display("FAIL stream_occ3: got %0d want 3", occupancy); end
        push(32'd4);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'd2) begin errors++; $display("FAIL stream_out2: got %b/%h want 1/2", out_valid, out_data); end
        checks++; if (occupancy !== 2'd3) begin errors++; $display("FAIL stream_occ_sat: got %0d want 3", occupancy); end
        clear_chain();
    endtask

    task automatic test_stall();
        push(32'd1); push(32'd2); push(32'd3);
        en = 1'b0; in_valid = 1'b1; in_data = 32'd9;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++; if (out_data !== 32'd1 || out_valid !== 1'b1) begin errors++; $display("FAIL stall_out cyc%0d: got %b/%h want 1/1", c, out_valid, out_data); end
            checks++; if (stage_valid !== 3'b111 || occupancy !== 2'd3) begin errors++; $display("FAIL stall_valid cyc%0d: got %b/%0d want 111/3", c, stage_valid, occupancy); end
        end
        en = 1'b1;
        step();
        checks++; if (out_data !== 32'd2) begin errors++; $display("FAIL stall_resume2: got %h want 2", out_data); end
        step();
        checks++; if (out_data !== 32'd3) begin errors++; $display("FAIL stall_resume3: got %h want 3", out_data); end
        step();
        checks++; if (out_data !== 32'd9 || out_valid !== 1'b1) begin errors++; $display("FAIL stall_resume9: got %b/%h want 1/9", out_valid, out_data); end
        clear_chain();
    endtask

    task automatic test_selective_flush();
        logic [31:0] exp_dead;
        push(32'hA); push(32'hB); push(32'hC);
        en = 1'b1; in_valid = 1'b1; in_data = 32'hD; flush_mask = 3'b010;
        step();
        checks++; if (stage_valid !== 3'b101 || occupancy !== 2'd2) begin errors++; $display("FAIL sel_flush_valid: got %b/%0d want 101/2", stage_valid, occupancy); end
        checks++; if (out_data !== 32'hB || out_valid !== 1'b1) begin errors++; $display("FAIL sel_flush_out: got %b/%h want 1/b", out_valid, out_data); end
        flush_mask = 3'b000; in_valid = 1'b0;
        step();
`ifdef PIPE_FLUSH_ZERO_EN
        exp_dead = 32'h0;
`else
        exp_dead = 32'hC;
`endif
        checks++; if (out_valid !== 1'b0 || out_data !== exp_dead) begin errors++; $display("FAIL sel_flush_dead: got %b/%h want 0/%h", out_valid, out_data, exp_dead); end
        checks++; if (stage_valid !== 3'b010 || occupancy !== 2'd1) begin errors++; $display("FAIL sel_flush_after: got %b/%0d want 010/1", stage_valid, occupancy); end
        clear_chain();
    endtask

    task automatic test_flush_stalled();
        logic [31:0] exp_dead;
        push(32'd1); push(32'd2); push(32'd3);
        en = 1'b0; in_valid = 1'b1; in_data = 32'h55; flush_mask = 3'b100;
        step();
`ifdef PIPE_FLUSH_ZERO_EN
        exp_dead = 32'h0;
`else
        exp_dead = 32'd1;
`endif
        checks++; if (out_valid !== 1'b0 || out_data !== exp_dead) begin errors++; $display("FAIL stall_flush_out: got %b/%h want 0/%h", out_valid, out_data, exp_dead); end
        checks++; if (stage_valid !== 3'b011 || occupancy !== 2'd2) begin errors++; $display("FAIL stall_flush_valid: got %b/%0d want 011/2", stage_valid, occupancy); end
        flush_mask = 3'b000; en = 1'b1; in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'd2) begin errors++; $display("FAIL stall_flush_kept2: got %b/%h want 1/2", out_valid, out_data); end
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'd3) begin errors++; $display("FAIL stall_flush_kept3: got %b/%h want 1/3", out_valid, out_data); end
        clear_chain();
    endtask

    task automatic test_full_flush_and_reset();
        push(32'd1); push(32'd2); push(32'd3);
        en = 1'b0; in_valid = 1'b1; flush_mask = 3'b111;
        step();
        checks++; if (stage_valid !== 3'b000 || occupancy !== 2'd0) begin errors++; $display("FAIL full_flush_stalled: got %b/%0d want 000/0", stage_valid, occupancy); end
        push(32'd4); push(32'd5); push(32'd6);
        en = 1'b1; in_valid = 1'b1; flush_mask = 3'b111;
        step();
        checks++; if (stage_valid !== 3'b000 || occupancy !== 2'd0) begin errors++; $display("FAIL full_flush_run: got %b/%0d want 000/0", stage_valid, occupancy); end
        push(32'd7); push(32'd8); push(32'd9);
        reset = 1'b0; en = 1'b1; in_valid = 1'b1; in_data = 32'h77;
        step();
        checks++; if (stage_valid !== 3'b000 || occupancy !== 2'd0 || out_data !== 32'h0) begin errors++; $display("FAIL mid_reset: got %b/%0d/%h want 000/0/0", stage_valid, occupancy, out_data); end
        reset = 1'b1; in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (out_valid !== 1'b0 || stage_valid !== 3'b000) begin errors++; $display("FAIL post_reset_empty cyc%0d: got %b/%b want 0/000", c, out_valid, stage_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall();
        test_selective_flush();
        test_flush_stalled();
        test_full_flush_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
